sqrt_iter: RTL and testbench
============================

SQRT_ITER -- requirements
Module: sqrt_iter

Interface
REQ-001 SHALL have parameter IN_W, default 12, meaning radicand width in bits (unsigned).
REQ-002 SHALL have parameter IN_FRAC, default 4, meaning fractional bits of radicand.
REQ-003 SHALL have parameter OUT_FRAC, default 16, meaning fractional bits of result.
REQ-004 SHALL derive localparams RAD_W = IN_W+2*OUT_FRAC-IN_FRAC rounded up to even, OUT_W = RAD_W/2, ITERS = OUT_W.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  radicand A presented.
REQ-008 SHALL have port in_ready  output  1  block can accept A.
REQ-009 SHALL have port A  input  IN_W  unsigned fixed-point radicand.
REQ-010 SHALL have port out_valid  output  1  Q valid, held until taken.
REQ-011 SHALL have port out_ready  input  1  consumer accepts Q.
REQ-012 SHALL have port Q  output  OUT_W  unsigned result, OUT_FRAC fractional bits.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL compute Q = floor(sqrt(A_int * 2^(2*OUT_FRAC-IN_FRAC))), A_int being A as integer; elaboration SHALL fail if 2*OUT_FRAC < IN_FRAC.
REQ-015 SHALL use radix-2 digit-by-digit (restoring) integer square root over RAD_W-bit zero-extended radicand, one result bit per cycle, no multipliers or dividers.
REQ-016 SHALL implement states IDLE, LOAD, ITER, ROUND, DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 captures A, clears remainder/root, goes LOAD.
REQ-018 LOAD: one cycle, aligns radicand, sets iteration counter to ITERS-1, goes ITER.
REQ-019 ITER: per cycle shifts two radicand bits into remainder, trial = (root<<2)|1, subtracts if remainder >= trial and sets root LSB; counter 0 goes ROUND, else decrements.
REQ-020 ROUND: one cycle, applies rounding per REQ-030/031, goes DONE.
REQ-021 DONE: out_valid=1, Q stable; out_valid&&out_ready returns to IDLE next cycle.
REQ-022 Latency from in_valid&&in_ready edge to out_valid SHALL be ITERS+2 cycles (22 at defaults).
REQ-023 in_ready SHALL be 0 outside IDLE; in_valid then SHALL be ignored, A not re-sampled.
REQ-024 out_ready while not DONE SHALL have no effect; Q SHALL hold last result until next capture.
REQ-025 A=0 SHALL yield Q=0 with the same latency (no early exit).
REQ-026 Internal remainder SHALL be OUT_W+2 bits, never overflowing for any A.

Reset
REQ-027 rst_=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, Q=0, counters/datapath zero.
REQ-028 Reset mid-computation SHALL abort silently; no out_valid pulse after release.
REQ-029 First capture SHALL be possible on the first rising edge after rst_ deasserts.

Configuration
REQ-030 With SQRT_ROUND_EN defined, ROUND SHALL increment root when final remainder > root (exact round-to-nearest), saturating at all-ones OUT_W.
REQ-031 Without SQRT_ROUND_EN, ROUND SHALL pass root unchanged (truncation); latency unchanged.

Structure
REQ-032 Shared package SHALL hold sqrt state enum type and default IN_FRAC/OUT_FRAC constants.
REQ-033 One sub-module sqrt_step (combinational single-iteration remainder/root update) is natural; FSM and registers stay in sqrt_iter.

Verification (defaults)
REQ-034 A=12'h040 (4.0) -> Q=20'h20000 both builds, out_valid 22 cycles after accept.
REQ-035 A=12'h020 (2.0) -> Q=20'h16A09 truncating, 20'h16A0A with SQRT_ROUND_EN.
REQ-036 A=12'hFFF -> Q=20'hFFF7F truncating, 20'hFFF80 with SQRT_ROUND_EN; A=0 -> Q=0.
REQ-037 Hold out_ready=0 ten cycles in DONE -> out_valid and Q stable; new in_valid ignored until handshake.
REQ-038 Assert rst_ at ITER cycle 7 -> outputs reset asynchronously, no out_valid; next A=12'h010 -> Q=20'h10000.
REQ-039 Back-to-back stream, in_valid and out_ready held high, 100 random A -> results match floor/round reference model in order.

Source files
------------

// File: rtl/sqrt_iter_pkg.sv
// Shared types and defaults for the iterative fixed-point square root.
package sqrt_iter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIter,
    StRound,
    StDone
  } sqrt_state_e;

  localparam int DefaultInFrac  = 4;
  localparam int DefaultOutFrac = 16;

  // Aligned radicand width, rounded up to an even bit count.
  function automatic int rad_width(input int in_w, input int in_frac, input int out_frac);
    int raw;
    raw = in_w + 2 * out_frac - in_frac;
    return raw + (raw % 2);
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One radix-2 restoring square-root iteration: consumes two radicand bits, yields one root bit.
module sqrt_step #(
  parameter int OUT_W = 20
) (
  input  logic [OUT_W+1:0] rem_i,
  input  logic [OUT_W-1:0] root_i,
  input  logic [1:0]       bits_i,
  output logic [OUT_W+1:0] rem_o,
  output logic [OUT_W-1:0] root_o
);

  logic [OUT_W+1:0] shifted;
  logic [OUT_W+1:0] trial;

  always_comb begin
    // Top remainder bits are always zero here, so the shift never loses information.
    shifted = (rem_i << 2) | {{OUT_W{1'b0}}, bits_i};
    trial   = {root_i, 2'b01};
    if (shifted >= trial) begin
      rem_o  = shifted - trial;
      root_o = (root_i << 1) | OUT_W'(1);
    end else begin
      rem_o  = shifted;
      root_o = root_i << 1;
    end
  end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative unsigned fixed-point square root, one result bit per cycle.
// Define SQRT_ROUND_EN for round-to-nearest; otherwise the result is truncated.
module sqrt_iter
  import sqrt_iter_pkg::*;
#(
  parameter int IN_W     = 12,
  parameter int IN_FRAC  = DefaultInFrac,
  parameter int OUT_FRAC = DefaultOutFrac,
  localparam int RAD_W   = rad_width(IN_W, IN_FRAC, OUT_FRAC),
  localparam int OUT_W   = RAD_W / 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Q,
  output logic             busy
);

  localparam int ITERS = OUT_W;
  localparam int SHIFT = (2 * OUT_FRAC >= IN_FRAC) ? 2 * OUT_FRAC - IN_FRAC : 0;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int REM_W = OUT_W + 2;

  if (2 * OUT_FRAC < IN_FRAC) begin : g_bad_frac
    $error("sqrt_iter: 2*OUT_FRAC must not be less than IN_FRAC");
  end

  sqrt_state_e state_q, state_d;

  logic [RAD_W-1:0] rad_q, rad_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] q_q, q_d;

  logic [REM_W-1:0] step_rem;
  logic [OUT_W-1:0] step_root;

  sqrt_step #(
    .OUT_W(OUT_W)
  ) u_step (
    .rem_i (rem_q),
    .root_i(root_q),
    .bits_i(rad_q[RAD_W-1 -: 2]),
    .rem_o (step_rem),
    .root_o(step_root)
  );

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StLoad;
      StLoad:  state_d = StIter;
      StIter:  if (cnt_q == '0) state_d = StRound;
      StRound: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    Q         = q_q;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
    end
  end

  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          rad_d  = RAD_W'(A);
          rem_d  = '0;
          root_d = '0;
        end
      end
      StLoad: begin
        rad_d = rad_q << SHIFT;
        cnt_d = CNT_W'(ITERS - 1);
      end
      StIter: begin
        rad_d  = rad_q << 2;
        rem_d  = step_rem;
        root_d = step_root;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      StRound: begin
`ifdef SQRT_ROUND_EN
        // rem > root means the true root lies at or beyond root + 0.5.
        if ((rem_q > {2'b00, root_q}) && !(&root_q)) begin
          q_d = root_q + OUT_W'(1);
        end else begin
          q_d = root_q;
        end
`else
        q_d = root_q;
`endif
      end
      StDone: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Self-checking bench for sqrt_iter against an arithmetic square-root reference model.
module tb_sqrt_iter;

  localparam int IN_W     = 12;
  localparam int IN_FRAC  = 4;
  localparam int OUT_FRAC = 16;
  localparam int OUT_W    = 20;
  localparam int LAT      = 22;

  logic             clk = 1'b0;
  logic             rst_;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  A;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] Q;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_iter #(
    .IN_W    (IN_W),
    .IN_FRAC (IN_FRAC),
    .OUT_FRAC(OUT_FRAC)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q        (Q),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Largest r with r*r <= A*2^(2*OUT_FRAC-IN_FRAC), optionally rounded to nearest.
  function automatic logic [OUT_W-1:0] ref_q(input logic [IN_W-1:0] a);
    longint unsigned r, lo, hi, mid;
    r  = 64'(a) << (2 * OUT_FRAC - IN_FRAC);
    lo = 0;
    hi = 64'(1) << (OUT_W + 1);
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
`ifdef SQRT_ROUND_EN
    if (4 * r >= (2 * lo + 1) * (2 * lo + 1)) lo = lo + 1;
    if (lo > (64'(1) << OUT_W) - 1) lo = (64'(1) << OUT_W) - 1;
`endif
    return lo[OUT_W-1:0];
  endfunction

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Issue one radicand from IDLE and consume its result.
  task automatic run_txn(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] exp, input string tag);
    int cyc;
    in_valid = 1'b1;
    A        = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_valid(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(LAT));
    check({tag, "_q"}, 64'(Q), 64'(exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_qhold"}, 64'(Q), 64'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    logic saw_valid;
    logic [IN_W-1:0] a;

    rst_      = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_q", 64'(Q), 64'd0);
    rst_ = 1'b0;

    run_txn(12'h040, 20'h20000, "four");
`ifdef SQRT_ROUND_EN
    run_txn(12'h020, 20'h16A0A, "two");
    run_txn(12'hFFF, 20'hFFF80, "max");
`else
    run_txn(12'h020, 20'h16A09, "two");
    run_txn(12'hFFF, 20'hFFF7F, "max");
`endif
    run_txn(12'h000, 20'h00000, "zero");

    // Stall in DONE with a competing request pending.
    in_valid = 1'b1;
    A        = 12'h020;
    @(posedge clk);
    #1;
    A = 12'h090;
    wait_valid(cyc);
    check("hold_lat", 64'(cyc), 64'(LAT));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_q", 64'(Q), 64'(ref_q(12'h020)));
      check("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("hold_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    check("next_lat", 64'(cyc), 64'(LAT));
    check("next_q", 64'(Q), 64'h30000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Abort in the middle of the iterations.
    in_valid = 1'b1;
    A        = 12'hABC;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_ = 1'b1;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_q", 64'(Q), 64'd0);
    @(posedge clk);
    #1;
    rst_      = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    check("abort_silent", 64'(saw_valid), 64'd0);
    run_txn(12'h010, 20'h10000, "post_rst");

    // Back-to-back stream with both handshakes held high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = 0;
      while (in_ready !== 1'b1 && w < 10) begin
        @(posedge clk);
        #1;
        w++;
      end
      a = 12'($urandom_range(0, 4095));
      if (i == 0) a = 12'hFFF;
      if (i == 1) a = 12'h000;
      if (i == 2) a = 12'h001;
      A = a;
      @(posedge clk);
      #1;
      wait_valid(cyc);
      check("stream_lat", 64'(cyc), 64'(LAT));
      check("stream_q", 64'(Q), 64'(ref_q(a)));
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
